// File: rtl/evcnt_pkg.sv
// Shared types and default constants for the event-count controller.
// The optional inactivity timeout is enabled by defining EVCNT_TIMEOUT_EN.
package evcnt_pkg;

  // Controller states; encodings are fixed so waveforms read the same in every build.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Default parameter values for the top level.
  localparam int DEF_WIDTH     = 4;
  localparam int DEF_TIMEOUT   = 16;
  localparam int DEF_TIMEOUT_W = 8;

endpackage

// File: rtl/evcnt_counter.sv
// Plain up-counter with asynchronous reset, synchronous clear and count enable.
// Clear wins over enable so a restart always begins from zero.
module evcnt_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  // Count register: clear has priority, otherwise advance when enabled.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/event_count_ctrl.sv
// Event-counting controller: after a start request it counts cycles with X=1
// up to a terminal count captured at start/reload, then pulses G for one cycle.
// Supports auto-reload, abort, and (with EVCNT_TIMEOUT_EN defined) an
// inactivity timeout that abandons a run after TIMEOUT idle COUNT cycles.
module event_count_ctrl
  import evcnt_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             S,
  input  logic             X,
  input  logic             ABORT,
  input  logic             AUTO,
  input  logic [WIDTH-1:0] TC,
  output logic             G,
  output logic [WIDTH-1:0] CNT,
  output logic             BUSY,
  output logic             TO
);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] tc_q;
  logic             start;     // entering COUNT: clear counters, capture TC
  logic             cnt_en;
  logic             timeout;
  logic             to_next;

  // Event counter; it only advances while below the captured terminal count.
  evcnt_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk(CLK),
    .rst(RST),
    .clr(start),
    .en (cnt_en),
    .cnt(CNT)
  );

`ifdef EVCNT_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] idle_cnt;

  // Idle counter: restarts on run entry or any event, grows on quiet COUNT cycles.
  evcnt_counter #(
    .WIDTH(TIMEOUT_W)
  ) u_idle (
    .clk(CLK),
    .rst(RST),
    .clr(start | X),
    .en ((state == COUNT) && !X),
    .cnt(idle_cnt)
  );

  assign timeout = (idle_cnt == TIMEOUT_W'(TIMEOUT));
`else
  assign timeout = 1'b0;
`endif

  // Next-state and datapath controls: abort, then terminal match, then timeout, then count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    next_state = state;
    start      = 1'b0;
    cnt_en     = 1'b0;
    to_next    = 1'b0;
    case (state)
      IDLE: begin
        if (S && !ABORT) begin
          next_state = COUNT;
          start      = 1'b1;
        end
      end
      COUNT: begin
        if (ABORT) begin
          next_state = IDLE;
        end else if (CNT == tc_q) begin
          next_state = DONE;
        end else if (timeout) begin
          next_state = IDLE;
          to_next    = 1'b1;
        end else if (X) begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        if (ABORT) begin
          next_state = IDLE;
        end else if (AUTO) begin
          next_state = COUNT;
          start      = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Terminal-count capture and registered status outputs derived from the next state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tc_q <= '0;
      G    <= 1'b0;
      BUSY <= 1'b0;
      TO   <= 1'b0;
    end else begin
      if (start) begin
        tc_q <= TC;
      end
      G    <= (next_state == DONE);
      BUSY <= (next_state != IDLE);
      TO   <= to_next;
    end
  end

endmodule

// File: doc/event_count_ctrl.md
# event_count_ctrl

Parametrised event-counting controller: after a start request it counts qualified event cycles on `X` up to a programmable terminal count, then pulses a one-cycle done flag `G`. It generalises the fixed 4-bit start/count/done controller with these additions:
- run-time terminal count;
- auto-reload mode;
- abort;
- optional inactivity timeout.

It sits between a sequencer issuing `S` and downstream logic consuming `G`.

## Interface
Parameters:
- `WIDTH`, 4: counter and terminal-count width; legal range 2..16.
- `TIMEOUT`, 16: idle cycles in COUNT before timeout abort; used only with the macro.
- `TIMEOUT_W`, 8: width of the idle counter; must satisfy `TIMEOUT < 2**TIMEOUT_W`.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `S`  in  1  start request; level, sampled in IDLE only.
- `X`  in  1  event qualifier; each cycle with `X`=1 in COUNT adds one.
- `ABORT`  in  1  cancel the run; highest priority after `RST`.
- `AUTO`  in  1  1 = reload and restart after DONE; 0 = return to IDLE.
- `TC`  in  WIDTH  terminal count; sampled into `tc_q` on start and on each reload.
- `G`  out  1  registered done pulse, high exactly in the DONE cycle.
- `CNT`  out  WIDTH  current count.
- `BUSY`  out  1  high in COUNT and DONE.
- `TO`  out  1  one-cycle timeout pulse; constant 0 without the macro.

One clock; reset is asynchronous and active-high.

## Operation
- States are IDLE, COUNT and DONE. `RST` forces the following immediately, independent of `CLK`:
  - state = IDLE;
  - `CNT` = 0, `tc_q` = 0, idle counter = 0;
  - `G` = 0, `BUSY` = 0, `TO` = 0.
- IDLE:
  - `S`=1 and `ABORT`=0: `CNT` <= 0, `tc_q` <= `TC`, next state COUNT.
  - Otherwise `CNT` holds its last value.
- COUNT, conditions checked in this priority order:
  1. `ABORT`: go to IDLE, `CNT` holds.
  2. `CNT` == `tc_q`: go to DONE, no increment even if `X`=1.
  3. `X`=1: `CNT` <= `CNT`+1.
  4. Otherwise hold.
- `TC`=0: COUNT exits to DONE on its first cycle regardless of `X`.
- `CNT` never exceeds `tc_q` and never wraps. `TC`=2^WIDTH−1 is legal.
- DONE lasts exactly one cycle with `G`=1. Next state:
  - `ABORT`=1: IDLE. `G` has already been issued in this cycle.
  - `AUTO`=1: COUNT, with `CNT` <= 0 and `tc_q` <= current `TC`.
  - `AUTO`=0: IDLE, `CNT` holds `tc_q`.
- `S` in COUNT or DONE is ignored; there is no restart mid-run.
- `TC` changes mid-run have no effect until the next start or reload.

## Timing
- `S` sampled at edge k:
  - after edge k: `BUSY`=1, `CNT`=0;
  - with `X`=1 continuously: `CNT` == `TC` after edge k+TC;
  - DONE and `G`=1 after edge k+TC+1;
  - IDLE, `G`=0, `BUSY`=0 after edge k+TC+2.
- Start-to-`G` latency is TC+1 cycles plus the number of cycles in which `X`=0.
- `ABORT` takes effect at the next edge. `G` is never asserted after an `ABORT` sampled in COUNT.
- Auto-reload: `G` pulses are separated by at least TC+2 cycles. `BUSY` stays high throughout.
- All outputs are registered; none has a combinational path from inputs.

## Configuration
- `EVCNT_TIMEOUT_EN` defined:
  - The idle counter clears on entry to COUNT and on any `X`=1.
  - It increments in each COUNT cycle with `X`=0.
  - When it reaches `TIMEOUT`, the next state is IDLE and `TO`=1 for one cycle. `G` is not asserted and `CNT` holds.
  - Priority order in COUNT: `ABORT` > terminal match > timeout.
- `EVCNT_TIMEOUT_EN` undefined: no idle counter, `TO` tied to 0, `TIMEOUT` and `TIMEOUT_W` unused.

## Structure
- Package `evcnt_pkg` holds:
  - the state typedef: IDLE=2'b00, COUNT=2'b01, DONE=2'b10;
  - the default-width constants.
- Sub-module `evcnt_counter`: `WIDTH`-bit up-counter with async `RST`, synchronous clear and enable. It is instantiated once for `CNT` and, under the macro, once more at `TIMEOUT_W` bits for the idle counter.
- The FSM and the `tc_q` register live in the top module.

## Test plan
- `WIDTH`=4, `TC`=5, `AUTO`=0, `S` pulsed at edge 0, `X`=1 continuously -> `CNT` reads 1..5; `G`=1 only after edge 6; `BUSY` falls after edge 7; `CNT` stays 5.
- `TC`=0, `S` pulsed -> `G`=1 after edge 1; `CNT`=0 throughout.
- `TC`=3, `AUTO`=1, `X`=1 continuously -> `G` after edges 4, 9, 14; `BUSY` never drops.
- `TC`=15, `ABORT` at `CNT`=7 -> IDLE next cycle; `CNT`=7; `G` never asserted; a following `S` restarts from 0.
- `RST` asserted mid-COUNT between clock edges -> all outputs 0 immediately; state is IDLE.
- `EVCNT_TIMEOUT_EN`, `TIMEOUT`=4, `TC`=10, `X` low after `CNT`=2 -> `TO`=1 four cycles later; `G`=0; `CNT`=2.
